rd_bram_burst: RTL

//  Parametrised BRAM port-B burst reader; successor of the single-beat row reader.
//  - One start request (base, length, stride) issues a multi-beat burst.
//  - Compensates configurable BRAM read latency.
//  - Buffers returned words in a credit-guarded FIFO with valid/ready output.
//  - Sits between the conv/fc controller and the feature-map BRAMs.

---
 rtl/rd_bram_burst_pkg.sv | 18 +
 rtl/rd_bram_burst_skid_fifo.sv | 39 +++
 rtl/rd_bram_burst.sv | 103 ++++++++++
 3 files changed

// File: rtl/rd_bram_burst_pkg.sv
// rd_bram_burst_pkg: shared FSM encoding, feature-map BRAM defaults and clog2 helper
package rd_bram_burst_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;
  localparam int FM_ADDR_W = 13;
  localparam int FM_DATA_W = 512;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rd_bram_burst_skid_fifo.sv
// rd_bram_burst_skid_fifo: first-word-fall-through FIFO with occupancy count
module rd_bram_burst_skid_fifo
  import rd_bram_burst_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 513,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    do_pop = pop && !empty;
    do_push = push && (count != (AW+1)'(DEPTH) || do_pop);
    dout = empty ? '0 : mem[rp];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/rd_bram_burst.sv
// rd_bram_burst: BRAM port-B burst reader with latency tag pipe and credit-guarded FWFT output.
// Optional per-beat stride enabled by defining RD_BRAM_STRIDE_EN (otherwise stride is 1).
module rd_bram_burst
  import rd_bram_burst_pkg::*;
#(
  parameter int ADDR_W     = FM_ADDR_W,
  parameter int DATA_W     = FM_DATA_W,
  parameter int LEN_W      = 8,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
`ifdef RD_BRAM_STRIDE_EN
  input  logic [ADDR_W-1:0] rd_stride,
`endif
  output logic              rd_idle,
  output logic              rd_done,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_doutb,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last
);
  localparam int CW = clog2(FIFO_DEPTH) + 1;
  rd_state_t state, nxt;
  logic [LEN_W-1:0] len_r, cnt;
  logic [ADDR_W-1:0] addr_r, iss_addr, step;
`ifdef RD_BRAM_STRIDE_EN
  logic [ADDR_W-1:0] stride_r;
`endif
  logic [CW-1:0] inflight, fifo_cnt;
  logic [RD_LATENCY-1:0] tag_v, tag_l;
  logic issue, iss_last, enb_last, push, pop, fifo_empty;
  // The first beat is issued straight from IDLE so the start cycle is not wasted.
  always_comb begin
`ifdef RD_BRAM_STRIDE_EN
    step = state == IDLE ? rd_stride : stride_r;
`else
    step = ADDR_W'(1);
`endif
    iss_addr = state == IDLE ? rd_base : addr_r;
    iss_last = state == IDLE ? rd_len == LEN_W'(1) : cnt == len_r - LEN_W'(1);
    issue = state == IDLE ? rd_start && rd_len != '0
          : state == ISSUE && ({1'b0, inflight} + {1'b0, fifo_cnt} < (CW+1)'(FIFO_DEPTH));
    pop = rd_valid && rd_ready;
    push = tag_v[RD_LATENCY-1];
    nxt = state == IDLE  ? (rd_start ? (rd_len == '0 ? DONE : rd_len == LEN_W'(1) ? DRAIN : ISSUE) : IDLE)
        : state == ISSUE ? (issue && iss_last ? DRAIN : ISSUE)
        : state == DRAIN ? (pop && rd_last ? DONE : DRAIN)
        : IDLE;
    rd_idle = state == IDLE;
    rd_done = state == DONE;
    rd_valid = !fifo_empty;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      len_r <= '0;
      cnt <= '0;
      addr_r <= '0;
`ifdef RD_BRAM_STRIDE_EN
      stride_r <= '0;
`endif
      bram_enb <= 1'b0;
      bram_addrb <= '0;
      enb_last <= 1'b0;
      inflight <= '0;
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && rd_start) len_r <= rd_len;
`ifdef RD_BRAM_STRIDE_EN
      if (state == IDLE && rd_start) stride_r <= rd_stride;
`endif
      if (issue) begin
        cnt <= state == IDLE ? LEN_W'(1) : cnt + LEN_W'(1);
        addr_r <= iss_addr + step;
      end
      bram_enb <= issue;
      bram_addrb <= issue ? iss_addr : '0;
      enb_last <= issue && iss_last;
      inflight <= inflight + CW'(issue) - CW'(push);
      tag_v <= RD_LATENCY'({tag_v, bram_enb});
      tag_l <= RD_LATENCY'({tag_l, enb_last});
    end
  rd_bram_burst_skid_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W + 1)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({tag_l[RD_LATENCY-1], bram_doutb}),
    .pop(pop),
    .dout({rd_last, rd_data}),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );
endmodule
